// File: rtl/ariane_axi.sv
// ariane_axi: AXI4+ATOP request/response bundle types used as the default
// bus types of axi_shim_ot (64-bit address, 64-bit data, 4-bit ID).
//   req_t  : AW/W/AR channels with valids, B/R ready
//   resp_t : AW/W/AR ready, B/R channels with valids
package ariane_axi;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 4;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_shim_pkg.sv
// axi_shim_pkg: shared definitions for axi_shim_ot.
//   wr_state_e  : write-issue FSM states
//   blen_width  : burst-length field width, max(1, clog2(NumWords))
//   pend_width  : outstanding-count width, clog2(MaxTxn+1)
package axi_shim_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    DRAIN_AW = 2'd2
  } wr_state_e;

  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [3:0] AxiCacheMod   = 4'b0010;
  localparam logic [1:0] AxiRespExokay = 2'b01;

  function automatic int unsigned blen_width(input int unsigned num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

  function automatic int unsigned pend_width(input int unsigned max_txn);
    return $clog2(max_txn + 1);
  endfunction

endpackage

// File: rtl/axi_shim_ot_if.sv
// axi_shim_ot_if: AXI request/response bundle.
//   req  : request channels, driven by the master
//   resp : response channels, driven by the slave
interface axi_shim_ot_if #(
  parameter type req_t  = ariane_axi::req_t,
  parameter type resp_t = ariane_axi::resp_t
);
  req_t  req;
  resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/txn_counter.sv
// txn_counter: up/down outstanding-transaction counter, saturating at 0 and
// MaxVal.
//   clk_i/rst_i : clock, async active-high reset
//   inc_i/dec_i : count up / down (both together cancel)
//   cnt_o       : current count
//   full_o      : count equals MaxVal
module txn_counter #(
  parameter int unsigned Width  = 3,
  parameter int unsigned MaxVal = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             full_o
);

  localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + Width'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/axi_shim_ot.sv
// axi_shim_ot: simple request/grant front end to an AXI master port with
// bounded outstanding reads and writes.
//   rd_*       : read request (AR) and pass-through R beats
//   wr_*       : write request (AW + whole W burst) and pass-through B
//   *_pending_o: outstanding transaction counts per direction
//   axi_req_o / axi_resp_i : AXI master port
module axi_shim_ot import axi_shim_pkg::*; #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxTxn    = 4,
  parameter type axi_req_t  = ariane_axi::req_t,
  parameter type axi_resp_t = ariane_axi::resp_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  rd_req_i,
  output logic                                  rd_gnt_o,
  input  logic [63:0]                           rd_addr_i,
  input  logic [blen_width(NumWords)-1:0]       rd_blen_i,
  input  logic [2:0]                            rd_size_i,
  input  logic [IdWidth-1:0]                    rd_id_i,
  input  logic                                  rd_rdy_i,
  output logic                                  rd_valid_o,
  output logic                                  rd_last_o,
  output logic [DataWidth-1:0]                  rd_data_o,
  output logic [IdWidth-1:0]                    rd_id_o,
  output logic                                  rd_exokay_o,
  input  logic                                  wr_req_i,
  output logic                                  wr_gnt_o,
  input  logic [63:0]                           wr_addr_i,
  input  logic [NumWords*DataWidth-1:0]         wr_data_i,
  input  logic [NumWords*DataWidth/8-1:0]       wr_be_i,
  input  logic [blen_width(NumWords)-1:0]       wr_blen_i,
  input  logic [2:0]                            wr_size_i,
  input  logic [IdWidth-1:0]                    wr_id_i,
  input  logic                                  wr_lock_i,
  input  logic [5:0]                            wr_atop_i,
  input  logic                                  wr_rdy_i,
  output logic                                  wr_valid_o,
  output logic [IdWidth-1:0]                    wr_id_o,
  output logic                                  wr_exokay_o,
  output logic [pend_width(MaxTxn)-1:0]         rd_pending_o,
  output logic [pend_width(MaxTxn)-1:0]         wr_pending_o,
  output axi_req_t                              axi_req_o,
  input  axi_resp_t                             axi_resp_i
);

  localparam int unsigned Bl    = blen_width(NumWords);
  localparam int unsigned PendW = pend_width(MaxTxn);
  localparam int unsigned StrbW = DataWidth / 8;

  axi_shim_ot_if #(.req_t(axi_req_t), .resp_t(axi_resp_t)) axi_bus ();

  axi_req_t  req;
  axi_resp_t resp;

  assign axi_bus.req  = req;
  assign axi_req_o    = axi_bus.req;
  assign axi_bus.resp = axi_resp_i;
  assign resp         = axi_bus.resp;

  // ---------------- read path ----------------
  logic rd_full, ar_valid, ar_hs, r_last_hs;

  assign ar_valid  = rd_req_i & ~rd_full;
  assign ar_hs     = ar_valid & resp.ar_ready;
  assign r_last_hs = resp.r_valid & rd_rdy_i & resp.r.last;
  assign rd_gnt_o  = ar_hs;

  assign rd_valid_o  = resp.r_valid;
  assign rd_last_o   = resp.r.last;
  assign rd_data_o   = resp.r.data;
  assign rd_id_o     = resp.r.id;
  assign rd_exokay_o = (resp.r.resp == AxiRespExokay);

  txn_counter #(.Width(PendW), .MaxVal(MaxTxn)) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (ar_hs),
    .dec_i  (r_last_hs),
    .cnt_o  (rd_pending_o),
    .full_o (rd_full)
  );

  // ---------------- write path ----------------
  wr_state_e      state_q, state_d;
  logic [Bl-1:0]  cnt_q, cnt_d;
  logic           aw_done_q, aw_done_d;
  logic           wr_full, aw_valid, w_valid, w_last, wr_gnt, aw_hs, b_hs;
  logic [31:0]    beat_idx;

  assign w_last   = (cnt_q == wr_blen_i);
  assign beat_idx = 32'(cnt_q);
  assign aw_hs    = aw_valid & resp.aw_ready;
  assign b_hs     = resp.b_valid & wr_rdy_i;

  // IDLE with a start condition behaves exactly like BUSY with nothing done
  // yet, so both share one branch; this gives the zero-cycle issue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    wr_gnt    = 1'b0;
    unique case (state_q)
      IDLE, BUSY: begin
        if ((state_q == BUSY) || (wr_req_i && !wr_full && !rst_i)) begin
          aw_valid = ~aw_done_q;
          w_valid  = 1'b1;
          if (resp.w_ready && w_last) begin
            cnt_d     = '0;
            aw_done_d = 1'b0;
            if (aw_done_q || resp.aw_ready) begin
              wr_gnt  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN_AW;
            end
          end else begin
            state_d   = BUSY;
            aw_done_d = aw_done_q | resp.aw_ready;
            if (resp.w_ready) begin
              cnt_d = cnt_q + Bl'(1);
            end
          end
        end
      end
      DRAIN_AW: begin
        aw_valid = 1'b1;
        if (resp.aw_ready) begin
          wr_gnt  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
    end
  end

  assign wr_gnt_o    = wr_gnt;
  assign wr_valid_o  = resp.b_valid;
  assign wr_id_o     = resp.b.id;
  assign wr_exokay_o = (resp.b.resp == AxiRespExokay);

  txn_counter #(.Width(PendW), .MaxVal(MaxTxn)) u_wr_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (aw_hs),
    .dec_i  (b_hs),
    .cnt_o  (wr_pending_o),
    .full_o (wr_full)
  );

  // ---------------- request assembly ----------------
  always_comb begin
    req = '0;

    req.ar_valid  = ar_valid;
    req.ar.id     = rd_id_i;
    req.ar.addr   = rd_addr_i;
    req.ar.len    = 8'(rd_blen_i);
    req.ar.size   = rd_size_i;
    req.ar.burst  = AxiBurstIncr;
    req.ar.lock   = 1'b0;
    req.ar.cache  = AxiCacheMod;
    req.r_ready   = rd_rdy_i;

    req.aw_valid  = aw_valid;
    req.aw.id     = wr_id_i;
    req.aw.addr   = wr_addr_i;
    req.aw.len    = 8'(wr_blen_i);
    req.aw.size   = wr_size_i;
    req.aw.burst  = AxiBurstIncr;
    req.aw.lock   = wr_lock_i;
    req.aw.cache  = AxiCacheMod;
    req.aw.atop   = wr_atop_i;

    req.w_valid   = w_valid;
    req.w.data    = wr_data_i[beat_idx*DataWidth +: DataWidth];
    req.w.strb    = wr_be_i[beat_idx*StrbW +: StrbW];
    req.w.last    = w_last;
    req.b_ready   = wr_rdy_i;
  end

endmodule

// File: tb/tb_axi_shim_ot.sv
module tb_axi_shim_ot;

  localparam int unsigned DW = 64;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned MT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic            rd_req_i, rd_gnt_o, rd_rdy_i, rd_valid_o, rd_last_o, rd_exokay_o;
  logic [63:0]     rd_addr_i;
  logic [1:0]      rd_blen_i;
  logic [2:0]      rd_size_i;
  logic [IW-1:0]   rd_id_i, rd_id_o;
  logic [DW-1:0]   rd_data_o;
  logic            wr_req_i, wr_gnt_o, wr_lock_i, wr_rdy_i, wr_valid_o, wr_exokay_o;
  logic [63:0]     wr_addr_i;
  logic [NW*DW-1:0]   wr_data_i;
  logic [NW*DW/8-1:0] wr_be_i;
  logic [1:0]      wr_blen_i;
  logic [2:0]      wr_size_i;
  logic [IW-1:0]   wr_id_i, wr_id_o;
  logic [5:0]      wr_atop_i;
  logic [1:0]      rd_pending_o, wr_pending_o;

  axi_shim_ot_if #(.req_t(ariane_axi::req_t), .resp_t(ariane_axi::resp_t)) axi ();

  axi_shim_ot #(
    .DataWidth (DW),
    .NumWords  (NW),
    .IdWidth   (IW),
    .MaxTxn    (MT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rd_req_i     (rd_req_i),
    .rd_gnt_o     (rd_gnt_o),
    .rd_addr_i    (rd_addr_i),
    .rd_blen_i    (rd_blen_i),
    .rd_size_i    (rd_size_i),
    .rd_id_i      (rd_id_i),
    .rd_rdy_i     (rd_rdy_i),
    .rd_valid_o   (rd_valid_o),
    .rd_last_o    (rd_last_o),
    .rd_data_o    (rd_data_o),
    .rd_id_o      (rd_id_o),
    .rd_exokay_o  (rd_exokay_o),
    .wr_req_i     (wr_req_i),
    .wr_gnt_o     (wr_gnt_o),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_be_i      (wr_be_i),
    .wr_blen_i    (wr_blen_i),
    .wr_size_i    (wr_size_i),
    .wr_id_i      (wr_id_i),
    .wr_lock_i    (wr_lock_i),
    .wr_atop_i    (wr_atop_i),
    .wr_rdy_i     (wr_rdy_i),
    .wr_valid_o   (wr_valid_o),
    .wr_id_o      (wr_id_o),
    .wr_exokay_o  (wr_exokay_o),
    .rd_pending_o (rd_pending_o),
    .wr_pending_o (wr_pending_o),
    .axi_req_o    (axi.req),
    .axi_resp_i   (axi.resp)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input int b);
    return 64'hD0D0_0000_0000_0000 | 64'(b);
  endfunction

  logic [7:0] strb_tab [4];

  typedef struct {
    logic       req, ar_rdy, r_vld, r_last, r_rdy;
    logic [1:0] r_resp;
    logic       e_arv, e_gnt, e_exok;
    logic [1:0] e_pend;
  } rvec_t;

  rvec_t rv [10];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    strb_tab[0] = 8'h01; strb_tab[1] = 8'h03; strb_tab[2] = 8'h07; strb_tab[3] = 8'hFF;
    //          req   ar_rdy r_vld r_last r_rdy resp    arv   gnt   exok  pend
    rv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'd1};
    rv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1};
    rv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'd2};
    rv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd2};
    rv[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 2'd2};
    rv[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd2};
    rv[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1};
    rv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 2'd1};
    rv[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0};
    rv[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0};

    rst_i = 1'b1;
    rd_req_i = 1'b0; rd_addr_i = 64'h1000_0040; rd_blen_i = 2'd3; rd_size_i = 3'd3;
    rd_id_i = 4'h2; rd_rdy_i = 1'b0;
    wr_req_i = 1'b0; wr_addr_i = 64'h2000_0000; wr_blen_i = 2'd3; wr_size_i = 3'd3;
    wr_id_i = 4'h5; wr_lock_i = 1'b0; wr_atop_i = 6'd0; wr_rdy_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_data_i[b*64 +: 64] = beat(b);
      wr_be_i[b*8 +: 8]     = strb_tab[b];
    end
    axi.resp = '0;

    step();
    step();
    // reset state; a request during reset must not raise aw_valid
    wr_req_i = 1'b1;
    #1;
    chk("rst_awv", 64'(axi.req.aw_valid), 64'd0);
    chk("rst_wv", 64'(axi.req.w_valid), 64'd0);
    chk("rst_gnt", 64'(wr_gnt_o), 64'd0);
    chk("rst_wpend", 64'(wr_pending_o), 64'd0);
    chk("rst_rpend", 64'(rd_pending_o), 64'd0);
    wr_req_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;

    // static AR fields
    chk("ar_len", 64'(axi.req.ar.len), 64'd3);
    chk("ar_burst", 64'(axi.req.ar.burst), 64'h1);
    chk("ar_cache", 64'(axi.req.ar.cache), 64'h2);
    chk("ar_addr", axi.req.ar.addr, 64'h1000_0040);
    chk("ar_lock", 64'(axi.req.ar.lock), 64'd0);

    // read path table
    for (int i = 0; i < 10; i++) begin
      rd_req_i             = rv[i].req;
      axi.resp.ar_ready    = rv[i].ar_rdy;
      axi.resp.r_valid     = rv[i].r_vld;
      axi.resp.r.last      = rv[i].r_last;
      axi.resp.r.resp      = rv[i].r_resp;
      axi.resp.r.data      = 64'hA5A5_0000_0000_0000 | 64'(i);
      axi.resp.r.id        = 4'(i);
      rd_rdy_i             = rv[i].r_rdy;
      #1;
      chk($sformatf("rd%0d_arv", i), 64'(axi.req.ar_valid), 64'(rv[i].e_arv));
      chk($sformatf("rd%0d_gnt", i), 64'(rd_gnt_o), 64'(rv[i].e_gnt));
      chk($sformatf("rd%0d_exok", i), 64'(rd_exokay_o), 64'(rv[i].e_exok));
      chk($sformatf("rd%0d_valid", i), 64'(rd_valid_o), 64'(rv[i].r_vld));
      chk($sformatf("rd%0d_last", i), 64'(rd_last_o), 64'(rv[i].r_last));
      chk($sformatf("rd%0d_data", i), rd_data_o, 64'hA5A5_0000_0000_0000 | 64'(i));
      chk($sformatf("rd%0d_rrdy", i), 64'(axi.req.r_ready), 64'(rv[i].r_rdy));
      step();
      chk($sformatf("rd%0d_pend", i), 64'(rd_pending_o), 64'(rv[i].e_pend));
    end
    rd_req_i = 1'b0; axi.resp.r_valid = 1'b0; axi.resp.ar_ready = 1'b0; rd_rdy_i = 1'b0;

    // 4-beat write, AW and W ready: beats back to back, grant with beat 3
    axi.resp.aw_ready = 1'b1; axi.resp.w_ready = 1'b1; wr_req_i = 1'b1;
    #1;
    chk("aw_addr", axi.req.aw.addr, 64'h2000_0000);
    chk("aw_len", 64'(axi.req.aw.len), 64'd3);
    chk("aw_id", 64'(axi.req.aw.id), 64'h5);
    chk("aw_cache", 64'(axi.req.aw.cache), 64'h2);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("a%0d_awv", b), 64'(axi.req.aw_valid), 64'(b == 0));
      chk($sformatf("a%0d_wv", b), 64'(axi.req.w_valid), 64'd1);
      chk($sformatf("a%0d_last", b), 64'(axi.req.w.last), 64'(b == 3));
      chk($sformatf("a%0d_data", b), axi.req.w.data, beat(b));
      chk($sformatf("a%0d_strb", b), 64'(axi.req.w.strb), 64'(strb_tab[b]));
      chk($sformatf("a%0d_gnt", b), 64'(wr_gnt_o), 64'(b == 3));
      step();
    end
    wr_req_i = 1'b0;
    #1;
    chk("a_pend", 64'(wr_pending_o), 64'd1);
    chk("a_idle_awv", 64'(axi.req.aw_valid), 64'd0);
    chk("a_idle_wv", 64'(axi.req.w_valid), 64'd0);
    chk("a_gnt_once", 64'(wr_gnt_o), 64'd0);

    // W completes before AW: drain AW, grant with the AW handshake
    axi.resp.aw_ready = 1'b0; wr_id_i = 4'h6; wr_req_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("b%0d_awv", b), 64'(axi.req.aw_valid), 64'd1);
      chk($sformatf("b%0d_last", b), 64'(axi.req.w.last), 64'(b == 3));
      chk($sformatf("b%0d_data", b), axi.req.w.data, beat(b));
      chk($sformatf("b%0d_gnt", b), 64'(wr_gnt_o), 64'd0);
      step();
    end
    #1;
    chk("b_drain_awv", 64'(axi.req.aw_valid), 64'd1);
    chk("b_drain_wv", 64'(axi.req.w_valid), 64'd0);
    chk("b_drain_gnt", 64'(wr_gnt_o), 64'd0);
    step();
    chk("b_drain_awv2", 64'(axi.req.aw_valid), 64'd1);
    chk("b_drain_pend", 64'(wr_pending_o), 64'd1);
    axi.resp.aw_ready = 1'b1;
    #1;
    chk("b_gnt", 64'(wr_gnt_o), 64'd1);
    step();
    wr_req_i = 1'b0;
    #1;
    chk("b_pend", 64'(wr_pending_o), 64'd2);
    chk("b_gnt_once", 64'(wr_gnt_o), 64'd0);

    // full at MaxTxn: no issue until a B handshake frees a slot
    wr_blen_i = 2'd0; wr_id_i = 4'h7; wr_req_i = 1'b1;
    #1;
    chk("c_full_awv", 64'(axi.req.aw_valid), 64'd0);
    chk("c_full_wv", 64'(axi.req.w_valid), 64'd0);
    chk("c_full_gnt", 64'(wr_gnt_o), 64'd0);
    step();
    chk("c_full_awv2", 64'(axi.req.aw_valid), 64'd0);
    axi.resp.b_valid = 1'b1; axi.resp.b.id = 4'h5; axi.resp.b.resp = 2'b01; wr_rdy_i = 1'b1;
    #1;
    chk("c_bvalid", 64'(wr_valid_o), 64'd1);
    chk("c_bid", 64'(wr_id_o), 64'h5);
    chk("c_bexok", 64'(wr_exokay_o), 64'd1);
    chk("c_b_awv", 64'(axi.req.aw_valid), 64'd0);
    step();
    axi.resp.b_valid = 1'b0;
    #1;
    chk("c_pend1", 64'(wr_pending_o), 64'd1);
    chk("c_awv", 64'(axi.req.aw_valid), 64'd1);
    chk("c_wv", 64'(axi.req.w_valid), 64'd1);
    chk("c_last", 64'(axi.req.w.last), 64'd1);
    chk("c_data", axi.req.w.data, beat(0));
    chk("c_gnt", 64'(wr_gnt_o), 64'd1);
    step();
    wr_req_i = 1'b0;
    #1;
    chk("c_pend2", 64'(wr_pending_o), 64'd2);

    // reset in the middle of a burst
    axi.resp.b_valid = 1'b1; axi.resp.b.resp = 2'b00;
    #1;
    chk("d_bexok", 64'(wr_exokay_o), 64'd0);
    step();
    axi.resp.b_valid = 1'b0;
    #1;
    chk("d_pend1", 64'(wr_pending_o), 64'd1);
    wr_blen_i = 2'd3; wr_req_i = 1'b1;
    step();
    step();
    #1;
    chk("d_beat2", axi.req.w.data, beat(2));
    chk("d_pend2", 64'(wr_pending_o), 64'd2);
    rst_i = 1'b1; wr_req_i = 1'b0;
    #1;
    chk("d_rst_awv", 64'(axi.req.aw_valid), 64'd0);
    chk("d_rst_wv", 64'(axi.req.w_valid), 64'd0);
    chk("d_rst_pend", 64'(wr_pending_o), 64'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("d_idle_awv", 64'(axi.req.aw_valid), 64'd0);
    chk("d_idle_wv", 64'(axi.req.w_valid), 64'd0);
    chk("d_idle_gnt", 64'(wr_gnt_o), 64'd0);
    axi.resp.b_valid = 1'b1;
    step();
    axi.resp.b_valid = 1'b0;
    #1;
    chk("d_late_b", 64'(wr_pending_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
